// File: rtl/mm_readback_pkg.sv
// Shared types and frame constants for the result-DRAM UART readback engine.
package mm_readback_pkg;

  localparam int ADDR_W_DEF      = 16;
  localparam int DATA_W_DEF      = 8;
  localparam int FRAME_DATA_BITS = 8;
  localparam int FRAME_BITS      = FRAME_DATA_BITS + 2;
  localparam logic START_BIT     = 1'b0;
  localparam logic STOP_BIT      = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    START,
    DATA,
    STOP,
    DONE
  } state_t;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 serialiser: baud counter plus a start/data/stop frame shifter; the line idles high.
module uart_tx_byte
  import mm_readback_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_byte,
  output logic              o_tx,
  output logic              o_frame_done
);

  localparam int FRAME_W = DATA_W + 2;
  localparam int CNT_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W   = $clog2(FRAME_W);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(FRAME_W - 1);

  logic [FRAME_W-1:0] frame;
  logic [CNT_W-1:0]   baud;
  logic [BIT_W-1:0]   bit_idx;
  logic               active;

  // The line is driven straight from the frame register, so reset forces it high at once.
  assign o_tx         = frame[0];
  assign o_frame_done = active && (baud == BAUD_LAST) && (bit_idx == LAST_BIT);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      frame   <= '1;
      baud    <= '0;
      bit_idx <= '0;
      active  <= 1'b0;
    end else if (i_load) begin
      frame   <= {STOP_BIT, i_byte, START_BIT};
      baud    <= '0;
      bit_idx <= '0;
      active  <= 1'b1;
    end else if (active) begin
      if (baud == BAUD_LAST) begin
        baud  <= '0;
        frame <= {STOP_BIT, frame[FRAME_W-1:1]};
        if (bit_idx == LAST_BIT) begin
          active  <= 1'b0;
          bit_idx <= '0;
        end else begin
          bit_idx <= bit_idx + 1'b1;
        end
      end else begin
        baud <= baud + 1'b1;
      end
    end
  end

endmodule

// File: rtl/dram_result_uart_tx.sv
// Reads a run of result bytes from DRAM and sends each one as an 8N1 UART frame.
module dram_result_uart_tx
  import mm_readback_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [ADDR_W-1:0] i_count,
  output logic              o_dram_read,
  output logic [ADDR_W-1:0] o_dram_addr,
  input  logic [DATA_W-1:0] i_dram_data,
  output logic              o_tx,
  output logic              o_busy,
  output logic              o_done
);

  state_t            state, next_state;
  logic [ADDR_W-1:0] addr, next_addr;
  logic [ADDR_W-1:0] remaining, next_remaining;
  logic              load;
  logic              frame_done;

  uart_tx_byte #(
    .DATA_W      (DATA_W),
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_load      (load),
    .i_byte      (i_dram_data),
    .o_tx        (o_tx),
    .o_frame_done(frame_done)
  );

  // The serialiser walks start/data/stop itself; the FSM parks in START until the frame ends.
  always_comb begin
    next_state     = state;
    next_addr      = addr;
    next_remaining = remaining;
    load           = 1'b0;
    case (state)
      IDLE: begin
        if (i_start) begin
          next_addr      = i_base_addr;
          next_remaining = i_count;
          next_state     = (i_count == '0) ? DONE : FETCH;
        end
      end
      FETCH: next_state = WAIT;
      WAIT: begin
        load       = 1'b1;
        next_state = START;
      end
      START, DATA, STOP: begin
        if (frame_done) begin
          next_remaining = remaining - 1'b1;
          next_addr      = addr + 1'b1;
          next_state     = (next_remaining == '0) ? DONE : FETCH;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs are registered from the next-state decode so they line up with the state they describe.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      addr        <= '0;
      remaining   <= '0;
      o_dram_read <= 1'b0;
      o_dram_addr <= '0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
    end else begin
      state       <= next_state;
      addr        <= next_addr;
      remaining   <= next_remaining;
      o_dram_read <= (next_state == FETCH);
      if (next_state == FETCH) o_dram_addr <= next_addr;
      o_busy      <= (next_state != IDLE);
      o_done      <= (next_state == DONE);
    end
  end

endmodule

// File: tb/tb_dram_result_uart_tx.sv
// Randomised bench for dram_result_uart_tx against a cycle-arithmetic model of the UART stream.
module tb_dram_result_uart_tx;

  localparam int C = 4;
  localparam int P = 2 + 10 * C;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] base_addr;
  logic [15:0] count;
  logic        dram_read;
  logic [15:0] dram_addr;
  logic [7:0]  dram_data;
  logic        tx;
  logic        busy;
  logic        done;

  int tests = 0;
  int fails = 0;

  logic [7:0]  mem [0:65535];
  logic [15:0] reads[$];
  logic        tx_s   [0:1023];
  logic        done_s [0:1023];
  logic        busy_s [0:1023];
  int          cap_len;

  always #5 clk = ~clk;

  dram_result_uart_tx #(
    .ADDR_W      (16),
    .DATA_W      (8),
    .CLKS_PER_BIT(C)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_base_addr(base_addr),
    .i_count    (count),
    .o_dram_read(dram_read),
    .o_dram_addr(dram_addr),
    .i_dram_data(dram_data),
    .o_tx       (tx),
    .o_busy     (busy),
    .o_done     (done)
  );

  always @(posedge clk) begin
    if (dram_read) begin
      dram_data <= mem[dram_addr];
      reads.push_back(dram_addr);
    end
  end

  function automatic int run_total(input int n);
    return (n == 0) ? 1 : 1 + n * P;
  endfunction

  // Expected line level in cycle k+j of a run of n bytes starting at base.
  function automatic logic exp_tx(input int j, input int n, input logic [15:0] base);
    int b, off, bit_i;
    logic [7:0] d;
    if (n == 0 || j < 1) return 1'b1;
    b   = (j - 1) / P;
    off = (j - 1) % P;
    if (b >= n || off < 2) return 1'b1;
    bit_i = (off - 2) / C;
    if (bit_i == 0) return 1'b0;
    if (bit_i == 9) return 1'b1;
    d = mem[16'(base + 16'(b))];
    return d[bit_i-1];
  endfunction

  function automatic int tx_errs(input int n, input logic [15:0] base);
    int e = 0;
    for (int j = 1; j <= cap_len; j++) if (tx_s[j] !== exp_tx(j, n, base)) e++;
    return e;
  endfunction

  function automatic int done_errs(input int n);
    int e = 0;
    for (int j = 1; j <= cap_len; j++) if (done_s[j] !== (j == run_total(n))) e++;
    return e;
  endfunction

  function automatic int busy_errs(input int n);
    int e = 0;
    for (int j = 1; j <= cap_len; j++) if (busy_s[j] !== (j <= run_total(n))) e++;
    return e;
  endfunction

  function automatic int read_errs(input int n, input logic [15:0] base);
    int e = 0;
    if (reads.size() != n) return 1000 + reads.size();
    for (int i = 0; i < n; i++) if (reads[i] !== 16'(base + 16'(i))) e++;
    return e;
  endfunction

  // Mid-bit sampling of the captured line, as a receiver would see it.
  function automatic int decode_errs(input int n, input logic [15:0] base);
    int e = 0;
    logic [7:0] got;
    for (int b = 0; b < n; b++) begin
      for (int i = 0; i < 8; i++) got[i] = tx_s[1 + b * P + 2 + C * (1 + i) + C / 2];
      if (got !== mem[16'(base + 16'(b))]) e++;
    end
    return e;
  endfunction

  task automatic capture(input logic [15:0] base, input int n, input int glitch_at);
    cap_len = run_total(n) + 3;
    @(negedge clk);
    base_addr = base;
    count     = 16'(n);
    start     = 1'b1;
    reads.delete();
    @(posedge clk);
    #1;
    start     = 1'b0;
    base_addr = 16'($urandom);
    count     = 16'($urandom_range(1, 20));
    for (int j = 1; j <= cap_len; j++) begin
      @(negedge clk);
      tx_s[j]   = tx;
      done_s[j] = done;
      busy_s[j] = busy;
      if (j == glitch_at) begin
        start     = 1'b1;
        base_addr = 16'($urandom);
        count     = 16'($urandom_range(1, 20));
      end else begin
        start = 1'b0;
      end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    tests++; if (tx !== 1'b1) begin fails++; $display("FAIL reset_tx: got %b want 1", tx); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests++; if (dram_read !== 1'b0) begin fails++; $display("FAIL reset_read: got %b want 0", dram_read); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done); end
    tests++; if (dram_addr !== 16'h0000) begin fails++; $display("FAIL reset_addr: got %h want 0000", dram_addr); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_byte;
    int e;
    mem[16'h0024] = 8'h7C;
    capture(16'h0024, 1, 0);
    e = tx_errs(1, 16'h0024);
    tests++; if (e !== 0) begin fails++; $display("FAIL single_tx: %0d cycles wrong, want 0", e); end
    tests++; if (done_s[43] !== 1'b1) begin fails++; $display("FAIL single_done_k43: got %b want 1", done_s[43]); end
    e = done_errs(1);
    tests++; if (e !== 0) begin fails++; $display("FAIL single_done: %0d cycles wrong, want 0", e); end
    e = read_errs(1, 16'h0024);
    tests++; if (e !== 0) begin fails++; $display("FAIL single_reads: err %0d, want 0", e); end
    e = busy_errs(1);
    tests++; if (e !== 0) begin fails++; $display("FAIL single_busy: %0d cycles wrong, want 0", e); end
  endtask

  task automatic test_burst;
    int e;
    for (int i = 0; i < 18; i++) mem[16'h0024 + 16'(i)] = 8'($urandom);
    capture(16'h0024, 18, 0);
    e = decode_errs(18, 16'h0024);
    tests++; if (e !== 0) begin fails++; $display("FAIL burst_decode: %0d bytes wrong, want 0", e); end
    e = tx_errs(18, 16'h0024);
    tests++; if (e !== 0) begin fails++; $display("FAIL burst_tx: %0d cycles wrong, want 0", e); end
    e = read_errs(18, 16'h0024);
    tests++; if (e !== 0) begin fails++; $display("FAIL burst_reads: err %0d, want 0", e); end
    e = done_errs(18);
    tests++; if (e !== 0) begin fails++; $display("FAIL burst_done: %0d cycles wrong, want 0", e); end
  endtask

  task automatic test_wrap;
    int e;
    capture(16'hFFFE, 3, 0);
    e = read_errs(3, 16'hFFFE);
    tests++; if (e !== 0) begin fails++; $display("FAIL wrap_reads: err %0d, want 0", e); end
    e = decode_errs(3, 16'hFFFE);
    tests++; if (e !== 0) begin fails++; $display("FAIL wrap_decode: %0d bytes wrong, want 0", e); end
    e = done_errs(3);
    tests++; if (e !== 0) begin fails++; $display("FAIL wrap_done: %0d cycles wrong, want 0", e); end
  endtask

  task automatic test_zero_count;
    int e;
    capture(16'h1234, 0, 0);
    e = done_errs(0);
    tests++; if (e !== 0) begin fails++; $display("FAIL zero_done: %0d cycles wrong, want 0", e); end
    tests++; if (reads.size() !== 0) begin fails++; $display("FAIL zero_reads: got %0d reads want 0", reads.size()); end
    e = tx_errs(0, 16'h1234);
    tests++; if (e !== 0) begin fails++; $display("FAIL zero_tx: %0d cycles low, want 0", e); end
    e = busy_errs(0);
    tests++; if (e !== 0) begin fails++; $display("FAIL zero_busy: %0d cycles wrong, want 0", e); end
  endtask

  task automatic test_start_while_busy;
    int e;
    logic [15:0] b;
    b = 16'($urandom_range(0, 16'hFF00));
    capture(b, 2, 30);
    e = read_errs(2, b);
    tests++; if (e !== 0) begin fails++; $display("FAIL busy_start_reads: err %0d, want 0", e); end
    e = tx_errs(2, b);
    tests++; if (e !== 0) begin fails++; $display("FAIL busy_start_tx: %0d cycles wrong, want 0", e); end
    e = done_errs(2);
    tests++; if (e !== 0) begin fails++; $display("FAIL busy_start_done: %0d cycles wrong, want 0", e); end
  endtask

  task automatic test_random_runs;
    int e, n;
    logic [15:0] b;
    for (int r = 0; r < 3; r++) begin
      b = 16'($urandom);
      n = $urandom_range(1, 4);
      capture(b, n, 0);
      e = tx_errs(n, b) + done_errs(n) + busy_errs(n) + read_errs(n, b);
      tests++; if (e !== 0) begin fails++; $display("FAIL random_run%0d: %0d errors, want 0", r, e); end
    end
  endtask

  task automatic test_reset_mid_data;
    int e = 0;
    mem[16'h0100] = 8'h00;
    mem[16'h0101] = 8'h00;
    @(negedge clk);
    base_addr = 16'h0100;
    count     = 16'd2;
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (8) @(negedge clk);
    tests++; if (tx !== 1'b0) begin fails++; $display("FAIL midrst_pre_tx: got %b want 0", tx); end
    #1 rst = 1'b1;
    #1;
    tests++; if (tx !== 1'b1) begin fails++; $display("FAIL midrst_tx: got %b want 1", tx); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL midrst_busy: got %b want 0", busy); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < 3 * P; j++) begin
      @(negedge clk);
      if (done !== 1'b0 || tx !== 1'b1 || dram_read !== 1'b0) e++;
    end
    tests++; if (e !== 0) begin fails++; $display("FAIL midrst_quiet: %0d active cycles, want 0", e); end
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    count     = '0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    test_reset;
    test_single_byte;
    test_burst;
    test_wrap;
    test_zero_count;
    test_start_while_busy;
    test_random_runs;
    test_reset_mid_data;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
